ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide execution unit for the RV32IM pipeline. It is the successor to the single-cycle execute stage, where ready_go is always 1.
- Sits beside the ALU in EX. The EX stage drives ex_ready_go from this unit, which stalls the pipeline until the result is available.
- Implements all eight RISC-V M-extension ops: an iterative radix-2 divider plus an optional single-cycle multiplier.
- Provides kill (branch flush) and busy/destination info for hazard detection.

Parameters:
- XLEN, 32, operand and result width.
- TAG_W, 5, width of the destination-register tag.
- FAST_MUL, 1. When 1, multiplies complete in 1 cycle via a combinational product. When 0, multiplies use an iterative shift-add of XLEN cycles.

Ports:
- clk  input  1  clock; single clock domain, all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operation request from EX.
- in_ready  output  1  unit can accept a request.
- in_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  input  XLEN  rs1 value.
- in_b  input  XLEN  rs2 value.
- in_rd  input  TAG_W  destination register.
- kill  input  1  flush (br_taken); aborts any operation.
- out_valid  output  1  result available.
- out_ready  input  1  MEM stage accepts the result.
- out_data  output  XLEN  result.
- out_rd  output  TAG_W  destination tag of the result.
- busy  output  1  operation in flight (CALC or DONE).
- busy_rd  output  TAG_W  destination tag of the in-flight operation, for ID hazard stall.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; out_valid=0, out_data=0, out_rd=0, busy=0, busy_rd=0; iteration counter=0.
- States:
  - IDLE: in_ready=1. A request is accepted when in_valid && in_ready && !kill; op, operands and rd are latched.
  - CALC: iterating. in_ready=0, busy=1.
  - DONE: out_valid=1, busy=1, in_ready=0. Holds out_data and out_rd stable until out_ready=1, then returns to IDLE the next cycle.
- Transitions from IDLE on accept (cycle t):
  - Special-case divides (divisor==0, or signed overflow) go directly to DONE; out_valid at t+1.
  - Multiplies with FAST_MUL=1 go directly to DONE; out_valid at t+1.
  - All other ops go to CALC with counter=XLEN-1. The counter decrements each cycle and moves to DONE after it reaches 0. out_valid is asserted at t+XLEN+1.
- No accept occurs in the same cycle as DONE→IDLE. Back-to-back issue is therefore at most one accept per XLEN+2 cycles for iterative ops, and one per 2 cycles for fast ops.
- kill: in any state, kill=1 forces state=IDLE and out_valid=0 at the next edge, and discards the result. kill in IDLE blocks the accept in that cycle. kill has priority over out_ready and in_valid. rst has priority over kill.
- Multiply:
  - Product is 2*XLEN bits.
  - Operand extension: MUL and MULH sign-extend both operands; MULHSU sign-extends a and zero-extends b; MULHU zero-extends both.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
  - Iterative mode uses XLEN shift-add steps on 2*XLEN-bit extended operands, with mod-2^(2*XLEN) wrap.
- Divide:
  - Signed ops (DIV, REM) take absolute values, run an XLEN-step unsigned restoring division, then negate: the quotient if the operand signs differ, the remainder if the dividend is negative.
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a; remainder = 0.
- Outputs are registered. out_data and out_rd change only on the transition into DONE.
- busy_rd holds the latched rd while busy=1, and is 0 otherwise.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2 accepted at cycle 0 → out_valid at cycle 33 with out_data 0xFFFFFFFD (-3); REM with the same operands → 0xFFFFFFFF (-1).
- DIVU a=100, b=0 → out_valid at cycle 1, out_data 0xFFFFFFFF; REMU a=100, b=0 → 100; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at cycle 1; REM with the same operands → 0.
- FAST_MUL=1:
  - MULH a=b=0x80000000 → 0x40000000; MUL with the same operands → 0.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF; MULHU with the same operands → 0xFFFFFFFE.
  - Repeat with FAST_MUL=0: same results, out_valid at cycle 33.
- kill asserted at cycle 10 of a DIVU → state returns to IDLE at cycle 11, out_valid never rises, in_ready=1 at cycle 11; a new MUL then completes normally.
- out_ready held at 0 for 5 cycles after DONE → out_valid, out_data, out_rd and busy_rd stay stable and in_valid is ignored; out_ready=1 → IDLE next cycle.
- rst asserted mid-CALC → all outputs 0 and in_ready=1 after the edge; simultaneous in_valid and kill in IDLE → no accept.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M multiply/divide unit (radix-2 divider, optional single-cycle multiplier)
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int FAST_MUL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_rd,
  output logic             busy,
  output logic [TAG_W-1:0] busy_rd
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [TAG_W-1:0] rd_q, rd_d, out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_data_q, out_data_d, b_q, b_d;
  logic [2*XLEN-1:0] a_q, a_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic na_q, na_d, nb_q, nb_d;
  logic is_div, sgn_a, sgn_b, na, nb, div0, ovf;
  logic [XLEN-1:0] abs_a, abs_b, fast_res, spec_res, calc_res, q, r;
  logic signed [XLEN:0] ea, eb;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN:0] trial;
  logic [2*XLEN-1:0] div_n, mul_n, a_sh, prod_it;
  assign is_div   = in_op[2];
  assign sgn_a    = is_div ? !in_op[0] : (in_op[1:0] != 2'b11);
  assign sgn_b    = is_div ? !in_op[0] : !in_op[1];
  assign na       = sgn_a & in_a[XLEN-1];
  assign nb       = sgn_b & in_b[XLEN-1];
  assign abs_a    = na ? -in_a : in_a;
  assign abs_b    = nb ? -in_b : in_b;
  assign div0     = in_b == '0;
  assign ovf      = !in_op[0] && in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1;
  assign ea       = $signed({na, in_a});
  assign eb       = $signed({nb, in_b});
  assign prod     = ea * eb;
  assign fast_res = in_op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign spec_res = div0 ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);
  // acc_q holds {remainder, dividend} for divides and the running product for multiplies
  assign trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
  assign div_n    = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0} : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign mul_n    = acc_q + (b_q[0] ? a_q : '0);
  assign a_sh     = a_q << 1;
  // after XLEN shifts a_sh equals a<<XLEN, which removes the missing sign weight of a negative b
  assign prod_it  = mul_n - (nb_q ? a_sh : '0);
  assign q        = div_n[XLEN-1:0];
  assign r        = div_n[2*XLEN-1:XLEN];
  assign calc_res = op_q[2] ? (op_q[1] ? (na_q ? -r : r) : ((na_q ^ nb_q) ? -q : q))
                            : (op_q[1:0] == 2'b00 ? prod_it[XLEN-1:0] : prod_it[2*XLEN-1:XLEN]);
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    na_d       = na_q;
    nb_d       = nb_q;
    if (kill) begin
      state_d = IDLE;
    end else if (state_q == IDLE && in_valid) begin
      op_d  = in_op;
      rd_d  = in_rd;
      na_d  = na;
      nb_d  = nb;
      a_d   = {{XLEN{na}}, in_a};
      b_d   = is_div ? abs_b : in_b;
      acc_d = is_div ? {{XLEN{1'b0}}, abs_a} : '0;
      if (is_div ? (div0 || ovf) : (FAST_MUL != 0)) begin
        state_d    = DONE;
        out_data_d = is_div ? spec_res : fast_res;
        out_rd_d   = in_rd;
      end else begin
        state_d = CALC;
        cnt_d   = CW'(XLEN-1);
      end
    end else if (state_q == CALC) begin
      acc_d = op_q[2] ? div_n : mul_n;
      a_d   = a_sh;
      b_d   = op_q[2] ? b_q : b_q >> 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d    = DONE;
        out_data_d = calc_res;
        out_rd_d   = rd_q;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      out_rd_q   <= '0;
      out_data_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      na_q       <= 1'b0;
      nb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      na_q       <= na_d;
      nb_q       <= nb_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign busy_rd   = busy ? rd_q : '0;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed scoreboard bench for both multiplier configurations of ex_muldiv_unit
module tb_ex_muldiv_unit;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  typedef struct {logic [31:0] d; logic [4:0] rd;} exp_t;
  logic clk = 1'b0, rst = 1'b1, ordy = 1'b0;
  logic [1:0] vld = '0, kil = '0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] rd = '0;
  logic ir[2], ov[2], bz[2];
  logic [31:0] od[2];
  logic [4:0] ord[2], brd[2];
  exp_t sb[$];
  int passes = 0, fails = 0, total = 0;
  always #5 clk = ~clk;
  ex_muldiv_unit #(.XLEN(32), .TAG_W(5), .FAST_MUL(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ir[0]), .in_op(op), .in_a(a), .in_b(b),
    .in_rd(rd), .kill(kil[0]), .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0]),
    .out_rd(ord[0]), .busy(bz[0]), .busy_rd(brd[0]));
  ex_muldiv_unit #(.XLEN(32), .TAG_W(5), .FAST_MUL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ir[1]), .in_op(op), .in_a(a), .in_b(b),
    .in_rd(rd), .kill(kil[1]), .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1]),
    .out_rd(ord[1]), .busy(bz[1]), .busy_rd(brd[1]));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic start(input int s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] e);
    exp_t n;
    @(negedge clk);
    op = o; a = x; b = y; rd = r; vld[s] = 1'b1;
    n.d = e; n.rd = r;
    sb.push_back(n);
    @(posedge clk); #1;
    vld[s] = 1'b0;
  endtask
  task automatic wait_out(input int s, input int elat, input string tag);
    int lat = 1;
    exp_t x;
    while (!ov[s] && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " data"}, od[s], x.d);
    chk({tag, " rd"}, 32'(ord[s]), 32'(x.rd));
    chk({tag, " busy_rd"}, 32'(brd[s]), 32'(x.rd));
  endtask
  task automatic release_out(input int s, input string tag);
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk({tag, " idle ready"}, {31'b0, ir[s]}, 32'd1);
    chk({tag, " idle valid"}, {31'b0, ov[s]}, 32'd0);
  endtask
  task automatic run(input int s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] r, input logic [31:0] e, input int elat, input string tag);
    start(s, o, x, y, r, e);
    wait_out(s, elat, tag);
    release_out(s, tag);
  endtask
  initial begin
    int seen;
    logic [31:0] hd;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", {31'b0, ov[1]}, 32'd0);
    chk("reset data", od[1], 32'd0);
    chk("reset busy", {31'b0, bz[1]}, 32'd0);
    chk("reset ready", {31'b0, ir[1]}, 32'd1);
    rst = 1'b0;
    run(1, DIV, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFD, 33, "div neg");
    run(1, REM, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFF, 33, "rem neg");
    run(1, DIVU, 32'd100, 32'd0, 5'd3, 32'hFFFFFFFF, 1, "divu by0");
    run(1, REMU, 32'd100, 32'd0, 5'd4, 32'd100, 1, "remu by0");
    run(1, DIV, 32'h80000000, 32'hFFFFFFFF, 5'd5, 32'h80000000, 1, "div ovf");
    run(1, REM, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'd0, 1, "rem ovf");
    run(1, DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33, "divu");
    run(1, REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33, "remu");
    run(1, MULH, 32'h80000000, 32'h80000000, 5'd9, 32'h40000000, 1, "fast mulh");
    run(1, MUL, 32'h80000000, 32'h80000000, 5'd10, 32'd0, 1, "fast mul");
    run(1, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFF, 1, "fast mulhsu");
    run(1, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE, 1, "fast mulhu");
    run(0, MULH, 32'h80000000, 32'h80000000, 5'd13, 32'h40000000, 33, "iter mulh");
    run(0, MUL, 32'h80000000, 32'h80000000, 5'd14, 32'd0, 33, "iter mul");
    run(0, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFF, 33, "iter mulhsu");
    run(0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'hFFFFFFFE, 33, "iter mulhu");
    run(0, MULH, 32'hFFFFFFFD, 32'd5, 5'd17, 32'hFFFFFFFF, 33, "iter mulh mixed");
    run(0, MUL, 32'hFFFFFFFD, 32'd5, 5'd18, 32'hFFFFFFF1, 33, "iter mul mixed");
    start(0, DIVU, 32'd1000, 32'd3, 5'd19, 32'd333);
    repeat (9) @(posedge clk);
    kil[0] = 1'b1;
    @(posedge clk); #1;
    kil[0] = 1'b0;
    void'(sb.pop_back());
    chk("kill ready", {31'b0, ir[0]}, 32'd1);
    chk("kill busy", {31'b0, bz[0]}, 32'd0);
    chk("kill busy_rd", 32'(brd[0]), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov[0]) seen++;
    end
    chk("kill no valid", 32'(seen), 32'd0);
    run(0, MUL, 32'd6, 32'd7, 5'd20, 32'd42, 33, "mul after kill");
    start(1, MULHU, 32'h00010000, 32'h00010000, 5'd21, 32'd1);
    wait_out(1, 1, "hold");
    hd = od[1];
    @(negedge clk);
    op = DIVU; a = 32'd5; b = 32'd1; rd = 5'd30; vld[1] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold valid", {31'b0, ov[1]}, 32'd1);
      chk("hold data", od[1], 32'd1);
      chk("hold rd", 32'(ord[1]), 32'd21);
      chk("hold busy_rd", 32'(brd[1]), 32'd21);
    end
    vld[1] = 1'b0;
    release_out(1, "hold");
    chk("hold data after release", od[1], hd);
    start(1, DIV, 32'hFFFFFFF9, 32'd2, 5'd22, 32'hFFFFFFFD);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    chk("rst valid", {31'b0, ov[1]}, 32'd0);
    chk("rst data", od[1], 32'd0);
    chk("rst rd", 32'(ord[1]), 32'd0);
    chk("rst busy", {31'b0, bz[1]}, 32'd0);
    chk("rst busy_rd", 32'(brd[1]), 32'd0);
    chk("rst ready", {31'b0, ir[1]}, 32'd1);
    @(negedge clk);
    op = MUL; a = 32'd3; b = 32'd3; rd = 5'd23; vld[1] = 1'b1; kil[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0; kil[1] = 1'b0;
    chk("kill blocks accept busy", {31'b0, bz[1]}, 32'd0);
    chk("kill blocks accept ready", {31'b0, ir[1]}, 32'd1);
    @(posedge clk); #1;
    chk("kill blocks accept valid", {31'b0, ov[1]}, 32'd0);
    run(1, MUL, 32'd3, 32'd3, 5'd24, 32'd9, 1, "mul after blocked");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
